// File: rtl/smg_pkg.sv
// Shared definitions for the smg debug-port reader: FSM encoding and the smg address width.
package smg_pkg;

    localparam int SMG_AW = 16;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ISSUE   = 3'd1,
        WAIT    = 3'd2,
        PRESENT = 3'd3,
        FINISH  = 3'd4
    } dumpState_t;

endpackage

// File: rtl/mem_dump_reader.sv
// Sweeps a block of smg data memory through its debug read port and streams the bytes
// out on a valid/ready byte interface while accumulating an 8-bit checksum.
module mem_dump_reader
    import smg_pkg::*;
#(
    parameter int READ_LAT = 1,      // legal range 1..7, fits the 3-bit wait counter
    parameter int AW       = SMG_AW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [AW-1:0] startAddress,
    input  logic [AW-1:0] length,
    output logic [AW-1:0] dataAddress,
    input  logic [7:0]    dataValue,
    output logic          outValid,
    output logic [7:0]    outData,
    input  logic          outReady,
    output logic          busy,
    output logic          done,
    output logic [7:0]    checksum,
    output logic [2:0]    dbgState
);

    localparam logic [2:0] WAIT_INIT = 3'(READ_LAT - 1);

    // Output byte stream: a byte transfers on the rising edge where outValid and
    // outReady are both high; outValid/outData stay frozen until that edge.
    dumpState_t    state_q;
    logic [AW-1:0] addr_q;
    logic [AW-1:0] rem_q;
    logic [2:0]    wait_q;
    logic [AW-1:0] data_addr_q;
    logic          out_valid_q;
    logic [7:0]    out_data_q;
    logic          done_q;
    logic [7:0]    checksum_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            rem_q       <= '0;
            wait_q      <= '0;
            data_addr_q <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= 8'h00;
            done_q      <= 1'b0;
            checksum_q  <= 8'h00;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        addr_q     <= startAddress;
                        rem_q      <= length;
                        checksum_q <= 8'h00;
                        state_q    <= (length == '0) ? FINISH : ISSUE;
                    end
                end
                ISSUE: begin
                    data_addr_q <= addr_q;
                    wait_q      <= WAIT_INIT;
                    state_q     <= WAIT;
                end
                WAIT: begin
                    if (wait_q == 3'd0) begin
                        out_data_q  <= dataValue;
                        out_valid_q <= 1'b1;
                        state_q     <= PRESENT;
                    end else begin
                        wait_q <= wait_q - 3'd1;
                    end
                end
                PRESENT: begin
                    if (outReady) begin
                        out_valid_q <= 1'b0;
                        checksum_q  <= checksum_q + out_data_q;
                        rem_q       <= rem_q - 1'b1;
                        addr_q      <= addr_q + 1'b1;
                        state_q     <= (rem_q != AW'(1)) ? ISSUE : FINISH;
                    end
                end
                FINISH: begin
                    done_q  <= 1'b1;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign dataAddress = data_addr_q;
    assign outValid    = out_valid_q;
    assign outData     = out_data_q;
    assign done        = done_q;
    assign checksum    = checksum_q;
    assign busy        = (state_q != IDLE);
    assign dbgState    = state_q;

endmodule

// File: tb/tb_mem_dump_reader.sv
// Directed bench for mem_dump_reader: one instance with READ_LAT=1 and one with READ_LAT=3,
// each fed by its own memory model with the matching latency.
module tb_mem_dump_reader;
    import smg_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        start_v [2];
    logic [15:0] startAddress;
    logic [15:0] length;
    logic        outReady;
    logic [15:0] da [2];
    logic [7:0]  dv [2];
    logic        ov [2];
    logic [7:0]  od [2];
    logic        bsy [2];
    logic        dn [2];
    logic [7:0]  cs [2];
    logic [2:0]  st [2];
    logic [15:0] a1, a2;

    int checks = 0;
    int errors = 0;

    logic [7:0]  exp_q[$];
    logic [15:0] exp_addr_q[$];

    always #5 clk = ~clk;

    mem_dump_reader #(.READ_LAT(1), .AW(16)) dut_lat1 (
        .clk(clk), .reset(reset), .start(start_v[0]), .startAddress(startAddress),
        .length(length), .dataAddress(da[0]), .dataValue(dv[0]), .outValid(ov[0]),
        .outData(od[0]), .outReady(outReady), .busy(bsy[0]), .done(dn[0]),
        .checksum(cs[0]), .dbgState(st[0])
    );

    mem_dump_reader #(.READ_LAT(3), .AW(16)) dut_lat3 (
        .clk(clk), .reset(reset), .start(start_v[1]), .startAddress(startAddress),
        .length(length), .dataAddress(da[1]), .dataValue(dv[1]), .outValid(ov[1]),
        .outData(od[1]), .outReady(outReady), .busy(bsy[1]), .done(dn[1]),
        .checksum(cs[1]), .dbgState(st[1])
    );

    function automatic logic [7:0] mem_f(input logic [15:0] a);
        case (a)
            16'h0010: return 8'h01;
            16'h0011: return 8'h02;
            16'h0012: return 8'h03;
            16'h0013: return 8'hFF;
            16'hFFFE: return 8'hA5;
            16'hFFFF: return 8'h5A;
            16'h0000: return 8'h3C;
            default:  return a[7:0] ^ 8'h55;
        endcase
    endfunction

    // Latency-1 memory answers combinationally; latency-3 memory delays the address two edges.
    assign dv[0] = mem_f(da[0]);
    always @(posedge clk) begin
        a1 <= da[1];
        a2 <= a1;
    end
    assign dv[1] = mem_f(a2);

    task automatic pulse_start(input int sel, input logic [15:0] base, input logic [15:0] len);
        @(negedge clk);
        startAddress = base;
        length       = len;
        start_v[sel] = 1'b1;
        @(negedge clk);
        start_v[sel] = 1'b0;
    endtask

    task automatic load_basic();
        exp_q      = '{8'h01, 8'h02, 8'h03, 8'hFF};
        exp_addr_q = '{16'h0010, 16'h0011, 16'h0012, 16'h0013};
    endtask

    task automatic load_wrap();
        exp_q      = '{8'hA5, 8'h5A, 8'h3C};
        exp_addr_q = '{16'hFFFE, 16'hFFFF, 16'h0000};
    endtask

    task automatic test_reset();
        reset        = 1'b0;
        start_v[0]   = 1'b1;
        start_v[1]   = 1'b1;
        startAddress = 16'h1234;
        length       = 16'h0004;
        outReady     = 1'b1;
        repeat (3) @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            checks++;
            if (da[s] !== 16'h0 || ov[s] !== 1'b0 || od[s] !== 8'h0 || bsy[s] !== 1'b0 ||
                dn[s] !== 1'b0 || cs[s] !== 8'h0 || st[s] !== 3'(IDLE)) begin
                errors++;
                $display("FAIL reset_values dut%0d: addr=%h valid=%b data=%h busy=%b done=%b cs=%h st=%0d, required all zero/IDLE",
                         s, da[s], ov[s], od[s], bsy[s], dn[s], cs[s], st[s]);
            end
        end
        start_v[0] = 1'b0;
        start_v[1] = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            checks++;
            if (bsy[s] !== 1'b0) begin
                errors++;
                $display("FAIL reset_release_busy dut%0d: busy=%b, required 0", s, bsy[s]);
            end
        end
    endtask

    // mode 0: outReady held high; mode 1: ready one cycle in three.
    // inject: a second start is pulsed mid-sweep and must be ignored.
    task automatic test_stream(input string name, input int sel, input logic [15:0] base,
                               input logic [15:0] len, input int mode, input bit inject,
                               input logic [7:0] exp_sum);
        int         c;
        bit         finished;
        bit         prev_hold;
        logic [7:0] prev_data;
        logic [7:0] e;
        logic [15:0] ea;
        outReady = 1'b0;
        pulse_start(sel, base, len);
        c = 0;
        finished = 1'b0;
        prev_hold = 1'b0;
        prev_data = 8'h00;
        while (!finished && c < 300) begin
            if (inject && c == 2) begin
                startAddress = 16'h0200;
                length       = 16'h0001;
                start_v[sel] = 1'b1;
            end else if (inject && c == 3) begin
                start_v[sel] = 1'b0;
            end
            if (prev_hold) begin
                checks++;
                if (ov[sel] !== 1'b1 || od[sel] !== prev_data) begin
                    errors++;
                    $display("FAIL %s hold: valid=%b data=%h, required valid=1 data=%h",
                             name, ov[sel], od[sel], prev_data);
                end
            end
            outReady = (mode == 0) ? 1'b1 : ((c % 3) == 0);
            if (ov[sel] === 1'b1 && outReady) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL %s extra_byte: data=%h, required no more bytes", name, od[sel]);
                end else begin
                    e  = exp_q.pop_front();
                    ea = exp_addr_q.pop_front();
                    if (od[sel] !== e || da[sel] !== ea) begin
                        errors++;
                        $display("FAIL %s byte: data=%h addr=%h, required data=%h addr=%h",
                                 name, od[sel], da[sel], e, ea);
                    end
                end
            end
            prev_hold = (ov[sel] === 1'b1) && !outReady;
            prev_data = od[sel];
            if (dn[sel] === 1'b1) finished = 1'b1;
            else begin
                c++;
                @(negedge clk);
            end
        end
        checks++;
        if (!finished) begin
            errors++;
            $display("FAIL %s timeout: done=0 after %0d cycles, required done pulse", name, c);
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s byte_count: %0d bytes missing, required 0", name, exp_q.size());
        end
        checks++;
        if (cs[sel] !== exp_sum) begin
            errors++;
            $display("FAIL %s checksum: got %h, required %h", name, cs[sel], exp_sum);
        end
        outReady = 1'b0;
        exp_q.delete();
        exp_addr_q.delete();
        repeat (3) begin
            @(negedge clk);
            checks++;
            if (dn[sel] !== 1'b0 || bsy[sel] !== 1'b0) begin
                errors++;
                $display("FAIL %s after_done: done=%b busy=%b, required 0/0", name, dn[sel], bsy[sel]);
            end
        end
    endtask

    task automatic test_zero_length();
        outReady = 1'b1;
        pulse_start(0, 16'h0040, 16'h0000);
        checks++;
        if (dn[0] !== 1'b0 || bsy[0] !== 1'b1) begin
            errors++;
            $display("FAIL zero_len_cycle1: done=%b busy=%b, required 0/1", dn[0], bsy[0]);
        end
        @(negedge clk);
        checks++;
        if (dn[0] !== 1'b1 || cs[0] !== 8'h00 || ov[0] !== 1'b0) begin
            errors++;
            $display("FAIL zero_len_done: done=%b cs=%h valid=%b, required 1/00/0", dn[0], cs[0], ov[0]);
        end
        @(negedge clk);
        checks++;
        if (dn[0] !== 1'b0 || ov[0] !== 1'b0 || bsy[0] !== 1'b0) begin
            errors++;
            $display("FAIL zero_len_after: done=%b valid=%b busy=%b, required 0/0/0", dn[0], ov[0], bsy[0]);
        end
        outReady = 1'b0;
    endtask

    task automatic test_reset_mid();
        int c;
        outReady = 1'b0;
        pulse_start(0, 16'h0010, 16'h0004);
        c = 0;
        while (ov[0] !== 1'b1 && c < 20) begin
            @(negedge clk);
            c++;
        end
        checks++;
        if (ov[0] !== 1'b1 || st[0] !== 3'(PRESENT)) begin
            errors++;
            $display("FAIL reset_mid_reach_present: valid=%b st=%0d, required 1/%0d", ov[0], st[0], PRESENT);
        end
        reset = 1'b0;
        #1;
        checks++;
        if (ov[0] !== 1'b0 || bsy[0] !== 1'b0 || od[0] !== 8'h00 || da[0] !== 16'h0) begin
            errors++;
            $display("FAIL reset_mid_abort: valid=%b busy=%b data=%h addr=%h, required 0/0/00/0000",
                     ov[0], bsy[0], od[0], da[0]);
        end
        @(negedge clk);
        reset = 1'b1;
        repeat (5) begin
            @(negedge clk);
            checks++;
            if (dn[0] !== 1'b0 || bsy[0] !== 1'b0) begin
                errors++;
                $display("FAIL reset_mid_no_done: done=%b busy=%b, required 0/0", dn[0], bsy[0]);
            end
        end
    endtask

    initial begin
        start_v[0]   = 1'b0;
        start_v[1]   = 1'b0;
        startAddress = 16'h0;
        length       = 16'h0;
        outReady     = 1'b0;
        reset        = 1'b0;
        test_reset();
        for (int s = 0; s < 2; s++) begin
            load_basic();
            test_stream("basic", s, 16'h0010, 16'h0004, 0, 1'b0, 8'h05);
            load_basic();
            test_stream("backpressure", s, 16'h0010, 16'h0004, 1, 1'b0, 8'h05);
            load_wrap();
            test_stream("wrap", s, 16'hFFFE, 16'h0003, 0, 1'b0, 8'h3B);
        end
        test_zero_length();
        load_basic();
        test_stream("start_ignored", 0, 16'h0010, 16'h0004, 0, 1'b1, 8'h05);
        test_reset_mid();
        load_basic();
        test_stream("after_reset", 0, 16'h0010, 16'h0004, 0, 1'b0, 8'h05);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, required finish before 200000");
        $fatal(1, "timeout");
    end

endmodule
